// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue
//
// Instruction-fetch stage with a decoupling prefetch queue. The stage
// generates the fetch PC, reads a combinational instruction ROM, and buffers
// {pc, instr} pairs in a DEPTH-entry FIFO. Decode drains the FIFO through a
// valid/ready handshake. A redirect from execute flushes the FIFO and restarts
// fetch at redirect_pc. While the queue is empty, decode sees NOP_INSTR.
//
// Optional feature macro: FETCH_JAL_PREDICT_EN
//   When defined, a JAL that is being enqueued steers the next fetch to its
//   target (fetch_pc + J-immediate). When undefined, fetch is purely
//   sequential (fetch_pc + 4) and no opcode decode is built.
//
// Ports:
//   clk            in   1     clock, rising edge
//   rst            in   1     asynchronous reset, active low
//   imem_addr      out  XLEN  ROM address (= fetch PC)
//   imem_en        out  1     fetch accepted this cycle
//   imem_rdata     in   XLEN  ROM data for imem_addr, same cycle
//   redirect_valid in   1     flush queue, restart fetch
//   redirect_pc    in   XLEN  new fetch address
//   out_valid      out  1     head entry present
//   out_ready      in   1     decode accepts head entry
//   out_pc         out  XLEN  PC of head entry (fetch PC when empty)
//   out_instr      out  XLEN  instruction of head entry (NOP when empty)
//   occupancy      out  $clog2(DEPTH+1)  entries stored
// ============================================================================
module fetch_queue #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            imem_addr,
    output logic                       imem_en,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]   count_q,    count_d;

    // Queue storage; not reset, contents are only meaningful below count_q
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] ins_mem [DEPTH];

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] next_pc;

    // ------------------------------------------------------------------
    // Next sequential / predicted fetch address
    // ------------------------------------------------------------------
`ifdef FETCH_JAL_PREDICT_EN
    logic            is_jal;
    logic [XLEN-1:0] jal_imm;

    // J-type immediate {imm[20], imm[10:1], imm[11], imm[19:12], 0},
    // sign-extended from imm[20] (instr bit 31).
    assign is_jal  = (imem_rdata[6:0] == 7'b1101111);
    assign jal_imm = {{(XLEN-20){imem_rdata[31]}},
                      imem_rdata[19:12],
                      imem_rdata[20],
                      imem_rdata[30:21],
                      1'b0};
    assign next_pc = is_jal ? (fetch_pc_q + jal_imm)
                            : (fetch_pc_q + XLEN'(4));
`else
    assign next_pc = fetch_pc_q + XLEN'(4);
`endif

    // ------------------------------------------------------------------
    // Per-cycle decisions and next-state
    // ------------------------------------------------------------------
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);

        // No bypass: a full queue never accepts a push, even alongside a pop.
        // The rst term keeps imem_en low for the whole reset assertion.
        push = !full && !redirect_valid && rst;
        pop  = !empty && out_ready && !redirect_valid;

        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            // Redirect wins over everything; the presented head is dropped.
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = next_pc;
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage write port; push is already low during reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
            ins_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr = fetch_pc_q;
    assign imem_en   = push;
    assign out_valid = !empty;
    assign out_pc    = empty ? fetch_pc_q : pc_mem[rd_ptr_q];
    assign out_instr = empty ? NOP_INSTR  : ins_mem[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue
//
// Directed testbench for fetch_queue (XLEN=32, DEPTH=4). The instruction ROM
// model returns the byte address itself as the instruction word, except that
// in JAL mode address 8 holds 32'h0200006F (jal x0, +32). Outputs are checked
// 1 time unit after each rising edge; inputs change at the same point.
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    logic        jal_mode;
    int          checks   = 0;
    int          failures = 0;

    fetch_queue #(
        .XLEN      (32),
        .DEPTH     (4),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (jal_mode && imem_addr == 32'h8) imem_rdata = 32'h0200_006F;
        else                                imem_rdata = imem_addr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; jal_mode = 1'b0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (out_instr !== 32'h13) begin failures++; $display("FAIL reset_out_instr got=%h want=00000013", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%h want=0", imem_addr); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL reset_imem_en got=%0b want=0", imem_en); end
        rst = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b1) begin failures++; $display("FAIL release_imem_en got=%0b want=1", imem_en); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL first_valid got valid=%0b pc=%h want valid=1 pc=0", out_valid, out_pc); end
        $display("reset: first entry pc=%h occ=%0d", out_pc, occupancy);
    endtask

    // ------------------------------------------------------------------
    task automatic test_fill;
        logic [31:0] exp_pc;
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks++; if (occupancy !== 3'(i)) begin failures++; $display("FAIL fill_occupancy got=%0d want=%0d", occupancy, i); end
        end
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL full_imem_en got=%0b want=0", imem_en); end
        checks++; if (imem_addr !== 32'd16) begin failures++; $display("FAIL full_imem_addr got=%h want=10", imem_addr); end
        tick();
        checks++; if (occupancy !== 3'd4 || imem_addr !== 32'd16) begin failures++; $display("FAIL full_hold got occ=%0d addr=%h want occ=4 addr=10", occupancy, imem_addr); end
        out_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== exp_pc) begin
                failures++;
                $display("FAIL drain got valid=%0b pc=%h instr=%h want valid=1 pc=%h instr=%h", out_valid, out_pc, out_instr, exp_pc, exp_pc);
            end
            $display("drain: pc=%h instr=%h occ=%0d", out_pc, out_instr, occupancy);
            tick();
            exp_pc = exp_pc + 32'd4;
        end
        checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL drain_occupancy got=%0d want=3", occupancy); end
        checks++; if (imem_addr !== 32'd44) begin failures++; $display("FAIL refill_addr got=%h want=2c", imem_addr); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_streaming;
        logic [31:0] exp_pc;
        redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h200) begin failures++; $display("FAIL stream_start got valid=%0b addr=%h want valid=0 addr=200", out_valid, imem_addr); end
        tick();
        exp_pc = 32'h200;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== exp_pc || occupancy !== 3'd1) begin
                failures++;
                $display("FAIL stream got valid=%0b pc=%h instr=%h occ=%0d want valid=1 pc=%h occ=1", out_valid, out_pc, out_instr, occupancy, exp_pc);
            end
            $display("stream: pc=%h instr=%h occ=%0d", out_pc, out_instr, occupancy);
            tick();
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_redirect_pop;
        out_ready = 1'b0;
        tick();
        tick();
        checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL pre_redirect_occ got=%0d want=3", occupancy); end
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL redirect_occ got=%0d want=0", occupancy); end
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h13) begin failures++; $display("FAIL redirect_empty got valid=%0b instr=%h want valid=0 instr=13", out_valid, out_instr); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL redirect_addr got=%h want=100", imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin failures++; $display("FAIL redirect_target got valid=%0b pc=%h want valid=1 pc=100", out_valid, out_pc); end
        $display("redirect: pc=%h occ=%0d", out_pc, occupancy);
    endtask

    // ------------------------------------------------------------------
    task automatic test_pc_wrap;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_start got=%h want=fffffffc", imem_addr); end
        tick();
        checks++; if (imem_addr !== 32'h0 || out_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got addr=%h pc=%h want addr=0 pc=fffffffc", imem_addr, out_pc); end
        tick();
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL wrap_out_pc got=%h want=0", out_pc); end
        $display("wrap: pc=%h addr=%h", out_pc, imem_addr);
    endtask

    // ------------------------------------------------------------------
    task automatic test_jal;
        logic [31:0] seq [5];
`ifdef FETCH_JAL_PREDICT_EN
        seq[0] = 32'd0; seq[1] = 32'd4; seq[2] = 32'd8; seq[3] = 32'd40; seq[4] = 32'd44;
`else
        seq[0] = 32'd0; seq[1] = 32'd4; seq[2] = 32'd8; seq[3] = 32'd12; seq[4] = 32'd16;
`endif
        jal_mode = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_addr !== seq[i] || imem_en !== 1'b1) begin
                failures++;
                $display("FAIL jal_seq step=%0d got addr=%h en=%0b want addr=%h en=1", i, imem_addr, imem_en, seq[i]);
            end
            $display("jal: fetch addr=%h rdata=%h", imem_addr, imem_rdata);
            tick();
        end
        jal_mode = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset;
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || imem_addr !== 32'h0 ||
            out_instr !== 32'h13 || out_pc !== 32'h0 || imem_en !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got valid=%0b occ=%0d addr=%h instr=%h pc=%h en=%0b", out_valid, occupancy, imem_addr, out_instr, out_pc, imem_en);
        end
        tick();
        checks++; if (occupancy !== 3'd0 || imem_en !== 1'b0) begin failures++; $display("FAIL reset_hold got occ=%0d en=%0b want occ=0 en=0", occupancy, imem_en); end
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL after_reset got valid=%0b pc=%h want valid=1 pc=0", out_valid, out_pc); end
        $display("async reset: pc=%h occ=%0d", out_pc, occupancy);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_streaming();
        test_redirect_pop();
        test_pc_wrap();
        test_jal();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
